// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op codes, default widths and
// the helper that decides whether an op produces a register write.
package alu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 4;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_SLT   = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd7;

    // Only the arithmetic/logic ops 0..4 deliver a result to the register file;
    // slt delivers a flag instead and 6/7 deliver nothing.
    function automatic logic writes_reg(input logic [2:0] op);
        return (op <= OP_SHIFT);
    endfunction

endpackage

// File: rtl/alu_fwd_match.sv
// Hazard compare for one source operand against the instruction in the issue
// register (distance 1) and the one in the writeback tag (distance 2).
// Distance 1 wins when both match, since it holds the younger value.
module alu_fwd_match
    import alu_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
)
(
    input  logic [REG_AW-1:0] src,
    input  logic              src_used,
    input  logic              iss_valid,
    input  logic              iss_wr,
    input  logic [REG_AW-1:0] iss_dst,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dst,
    output logic              sel_alu_issue,
    output logic              sel_alu_wb,
    output logic              stall
);

    logic hit_issue;
    logic hit_wb;

    // iss_wr is already cleared for slt and NOP, so those never match
    assign hit_issue     = src_used & iss_valid & iss_wr & (src == iss_dst);
    assign hit_wb        = src_used & wb_valid & (src == wb_dst);
    assign sel_alu_issue = hit_issue;
    assign sel_alu_wb    = hit_wb & ~hit_issue;
    assign stall         = hit_issue | hit_wb;

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/issue stage in front of the registered 16-bit ALU. Accepts one
// decoded instruction per cycle, drives the ALU operands and tags the ALU
// result into a writeback bundle one cycle after the ALU samples it.
// Build option ALU_ISSUE_FWD_EN: when defined, RAW hazards against the two
// youngest in-flight results are forwarded from alu_R; when undefined the
// stage stalls the dependent instruction until the register file is current.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int IMM_W  = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_imm_sel,
    input  logic [REG_AW-1:0] in_src_a,
    input  logic [REG_AW-1:0] in_src_b,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_wr_en,
    input  logic              hold,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_R,
    input  logic              alu_AltB,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_valid,
    output logic              flag
);

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    logic                     core_ready;
    logic                     accept;
    logic                     hazard_stall;
    logic signed [DATA_W-1:0] imm_ext;
    logic signed [DATA_W-1:0] a_next;
    logic signed [DATA_W-1:0] b_next;

    logic                     a_sel_iss, a_sel_wb, a_stall;
    logic                     b_sel_iss, b_sel_wb, b_stall;

    logic                     vld_p0;
    logic [2:0]               op_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic [REG_AW-1:0]        dst_p0;
    logic                     wr_p0;

    logic                     wb_vld_p1;
    logic                     flag_vld_p1;
    logic [REG_AW-1:0]        wb_dst_p1;

    // Reset is kept out of accept so it only acts through the async clear
    assign core_ready = ~hold & ~hazard_stall;
    assign in_ready   = rst_n & core_ready;
    assign accept     = in_valid & core_ready;
    assign imm_ext    = sext_imm(in_imm);

    alu_fwd_match #(.REG_AW(REG_AW)) u_match_a (
        .src           (in_src_a),
        .src_used      (1'b1),
        .iss_valid     (vld_p0),
        .iss_wr        (wr_p0),
        .iss_dst       (dst_p0),
        .wb_valid      (wb_vld_p1),
        .wb_dst        (wb_dst_p1),
        .sel_alu_issue (a_sel_iss),
        .sel_alu_wb    (a_sel_wb),
        .stall         (a_stall)
    );

    // An immediate B has no source register, so it can never hazard
    alu_fwd_match #(.REG_AW(REG_AW)) u_match_b (
        .src           (in_src_b),
        .src_used      (~in_imm_sel),
        .iss_valid     (vld_p0),
        .iss_wr        (wr_p0),
        .iss_dst       (dst_p0),
        .wb_valid      (wb_vld_p1),
        .wb_dst        (wb_dst_p1),
        .sel_alu_issue (b_sel_iss),
        .sel_alu_wb    (b_sel_wb),
        .stall         (b_stall)
    );

`ifdef ALU_ISSUE_FWD_EN
    logic fwd_a_p0;
    logic fwd_b_p0;
    logic unused_stall;

    assign hazard_stall = 1'b0;
    assign unused_stall = a_stall | b_stall;
    // Distance 2: producer is in writeback now, so alu_R is its result
    assign a_next = a_sel_wb ? alu_R : in_a;
    assign b_next = in_imm_sel ? imm_ext : (b_sel_wb ? alu_R : in_b);

    // Distance 1: producer is sampled by the ALU at this accept, so its
    // result only appears on alu_R during the consumer's issue cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_p0 <= 1'b0;
            fwd_b_p0 <= 1'b0;
        end else if (accept) begin
            fwd_a_p0 <= a_sel_iss;
            fwd_b_p0 <= b_sel_iss;
        end else begin
            fwd_a_p0 <= 1'b0;
            fwd_b_p0 <= 1'b0;
        end
    end

    assign alu_A = fwd_a_p0 ? alu_R : a_p0;
    assign alu_B = fwd_b_p0 ? alu_R : b_p0;
`else
    logic unused_sel;

    assign hazard_stall = a_stall | b_stall;
    assign unused_sel   = a_sel_iss | a_sel_wb | b_sel_iss | b_sel_wb;
    assign a_next       = in_a;
    assign b_next       = in_imm_sel ? imm_ext : in_b;
    assign alu_A        = a_p0;
    assign alu_B        = b_p0;
`endif

    // ---- p0: issue register, drives the ALU for one cycle ----
    // Latch an accepted instruction; otherwise issue a NOP so the ALU holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            op_p0  <= OP_NOP;
            a_p0   <= '0;
            b_p0   <= '0;
            dst_p0 <= '0;
            wr_p0  <= 1'b0;
        end else if (accept) begin
            vld_p0 <= 1'b1;
            op_p0  <= (in_op > OP_SLT) ? OP_NOP : in_op;
            a_p0   <= a_next;
            b_p0   <= b_next;
            dst_p0 <= in_dst;
            wr_p0  <= in_wr_en & writes_reg(in_op);
        end else begin
            vld_p0 <= 1'b0;
            op_p0  <= OP_NOP;
            wr_p0  <= 1'b0;
        end
    end

    // ---- p1: writeback tag, aligned with the ALU's registered result ----
    // Tag the instruction the ALU is sampling this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_vld_p1   <= 1'b0;
            flag_vld_p1 <= 1'b0;
            wb_dst_p1   <= '0;
        end else begin
            wb_vld_p1   <= vld_p0 & wr_p0;
            flag_vld_p1 <= vld_p0 & (op_p0 == OP_SLT);
            wb_dst_p1   <= dst_p0;
        end
    end

    assign alu_op     = op_p0;
    assign wb_valid   = wb_vld_p1;
    assign wb_dst     = wb_dst_p1;
    assign wb_data    = alu_R;
    assign flag_valid = flag_vld_p1;
    assign flag       = alu_AltB;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural registered ALU and a
// register file that is written on the DUT writeback and read into in_a/in_b.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_imm_sel, in_wr_en, hold;
    logic [2:0]  in_op;
    logic [15:0] in_a, in_b;
    logic [7:0]  in_imm;
    logic [3:0]  in_src_a, in_src_b, in_dst;
    logic [15:0] alu_A, alu_B, wb_data;
    logic [2:0]  alu_op;
    logic [15:0] alu_R = 16'h0000;
    logic        alu_AltB = 1'b0;
    logic        wb_valid, flag_valid, flag;
    logic [3:0]  wb_dst;

    logic [15:0] rf [16];
    logic        rf_clr;
    logic [15:0] alu_nb;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ALU_ISSUE_FWD_EN
    localparam int EXP_STALL_D1 = 0;
    localparam int EXP_STALL_D2 = 0;
`else
    localparam int EXP_STALL_D1 = 2;
    localparam int EXP_STALL_D2 = 1;
`endif

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] data;
    } wb_t;
    wb_t  wb_q[$];
    logic flag_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [7:0]  imm;
        logic        isel;
        logic [3:0]  dst;
        logic        wr;
        logic        ewb;
        logic [15:0] edata;
        logic        efv;
        logic        eflag;
    } vec_t;
    vec_t tv[13];

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_imm     (in_imm),
        .in_imm_sel (in_imm_sel),
        .in_src_a   (in_src_a),
        .in_src_b   (in_src_b),
        .in_dst     (in_dst),
        .in_wr_en   (in_wr_en),
        .hold       (hold),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .alu_R      (alu_R),
        .alu_AltB   (alu_AltB),
        .wb_valid   (wb_valid),
        .wb_dst     (wb_dst),
        .wb_data    (wb_data),
        .flag_valid (flag_valid),
        .flag       (flag)
    );

    // Register file: reads feed the operand inputs, writes land at the wb edge
    assign in_a = rf[in_src_a];
    assign in_b = rf[in_src_b];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= (i == 1) ? 16'd0 : 16'(i);
        end else if (wb_valid) begin
            rf[wb_dst] <= wb_data;
        end
    end

    // Registered ALU model; shift direction follows the sign of B
    assign alu_nb = -alu_B;
    always @(posedge clk) begin
        case (alu_op)
            3'd0: alu_R <= alu_A & alu_B;
            3'd1: alu_R <= alu_A | alu_B;
            3'd2: alu_R <= alu_A + alu_B;
            3'd3: alu_R <= alu_A - alu_B;
            3'd4: alu_R <= alu_B[15] ? (alu_A >> alu_nb[3:0]) : (alu_A << alu_B[3:0]);
            3'd5: alu_AltB <= ($signed(alu_A) < $signed(alu_B));
            default: ;
        endcase
    end

    // Writeback/flag monitor
    always @(negedge clk) begin
        if (wb_valid)   wb_q.push_back('{wb_dst, wb_data});
        if (flag_valid) flag_q.push_back(flag);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input string name, input logic [3:0] d, input logic [15:0] v);
        n_cmp++;
        if (wb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no register write seen, expected r%0d=%h", name, d, v);
        end else begin
            wb_t e;
            e = wb_q.pop_front();
            if (e.dst !== d || e.data !== v) begin
                n_bad++;
                $display("FAIL %s: got r%0d=%h expected r%0d=%h", name, e.dst, e.data, d, v);
            end
        end
    endtask

    task automatic exp_flag(input string name, input logic v);
        n_cmp++;
        if (flag_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no flag update seen, expected %0b", name, v);
        end else begin
            logic f;
            f = flag_q.pop_front();
            if (f !== v) begin
                n_bad++;
                $display("FAIL %s: got flag %0b expected %0b", name, f, v);
            end
        end
    endtask

    task automatic exp_none(input string name);
        chk({name, "_extra_wb"}, wb_q.size(), 0);
        chk({name, "_extra_flag"}, flag_q.size(), 0);
        wb_q.delete();
        flag_q.delete();
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic rf_reinit();
        rf_clr = 1'b1;
        @(posedge clk);
        #1;
        rf_clr = 1'b0;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [3:0] sa, input logic [3:0] sb,
                             input logic [7:0] imm, input logic isel, input logic [3:0] dst,
                             input logic wr);
        in_op = op; in_src_a = sa; in_src_b = sb; in_imm = imm;
        in_imm_sel = isel; in_dst = dst; in_wr_en = wr;
    endtask

    // Present one instruction until accepted; returns cycles spent with in_ready low.
    // Returns at accept edge + 1.
    task automatic send(input logic [2:0] op, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [7:0] imm, input logic isel, input logic [3:0] dst,
                        input logic wr, output int stalls);
        set_instr(op, sa, sb, imm, isel, dst, wr);
        in_valid = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int st;

        tv[0]  = '{3'd0, 4'd12, 4'd10, 8'h00, 1'b0, 4'd8,  1'b1, 1'b1, 16'h0008, 1'b0, 1'b0};
        tv[1]  = '{3'd1, 4'd12, 4'd3,  8'h00, 1'b0, 4'd8,  1'b1, 1'b1, 16'h000F, 1'b0, 1'b0};
        tv[2]  = '{3'd2, 4'd15, 4'd0,  8'hFF, 1'b1, 4'd8,  1'b1, 1'b1, 16'h000E, 1'b0, 1'b0};
        tv[3]  = '{3'd3, 4'd2,  4'd7,  8'h00, 1'b0, 4'd8,  1'b1, 1'b1, 16'hFFFB, 1'b0, 1'b0};
        tv[4]  = '{3'd4, 4'd3,  4'd0,  8'h02, 1'b1, 4'd8,  1'b1, 1'b1, 16'h000C, 1'b0, 1'b0};
        tv[5]  = '{3'd4, 4'd12, 4'd0,  8'hFE, 1'b1, 4'd8,  1'b1, 1'b1, 16'h0003, 1'b0, 1'b0};
        tv[6]  = '{3'd5, 4'd2,  4'd7,  8'h00, 1'b0, 4'd8,  1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[7]  = '{3'd5, 4'd7,  4'd0,  8'h80, 1'b1, 4'd8,  1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[8]  = '{3'd6, 4'd2,  4'd3,  8'h00, 1'b0, 4'd8,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[9]  = '{3'd7, 4'd2,  4'd3,  8'h00, 1'b0, 4'd8,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[10] = '{3'd2, 4'd5,  4'd6,  8'h00, 1'b0, 4'd8,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tv[11] = '{3'd3, 4'd3,  4'd0,  8'h7F, 1'b1, 4'd15, 1'b1, 1'b1, 16'hFF84, 1'b0, 1'b0};
        tv[12] = '{3'd2, 4'd5,  4'd6,  8'h00, 1'b0, 4'd0,  1'b1, 1'b1, 16'h000B, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0; rf_clr = 1'b1;
        set_instr(3'd0, 4'd0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rf_clr = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",   in_ready,   0);
        chk("rst_wb_valid",   wb_valid,   0);
        chk("rst_wb_dst",     wb_dst,     0);
        chk("rst_flag_valid", flag_valid, 0);
        chk("rst_alu_op",     alu_op,     7);
        chk("rst_alu_A",      alu_A,      0);
        chk("rst_alu_B",      alu_B,      0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: add r1 = r5 + r3
        send(3'd2, 4'd5, 4'd3, 8'h00, 1'b0, 4'd1, 1'b1, st);
        chk("lat_alu_op", alu_op, 2);
        chk("lat_alu_A",  alu_A,  5);
        chk("lat_alu_B",  alu_B,  3);
        chk("lat_wb_early", wb_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_wb_valid", wb_valid, 1);
        chk("lat_wb_dst",   wb_dst,   1);
        chk("lat_wb_data",  wb_data,  16'h0008);
        chk("lat_bubble_op", alu_op,  7);
        @(posedge clk);
        #1;
        chk("lat_wb_drop", wb_valid, 0);
        drain();
        exp_wb("lat_q", 4'd1, 16'h0008);
        exp_none("lat");

        // Table of independent single instructions
        rf_reinit();
        for (int i = 0; i < 13; i++) begin
            send(tv[i].op, tv[i].sa, tv[i].sb, tv[i].imm, tv[i].isel, tv[i].dst, tv[i].wr, st);
            drain();
            if (tv[i].ewb) exp_wb($sformatf("vec%0d_wb", i), tv[i].dst, tv[i].edata);
            if (tv[i].efv) exp_flag($sformatf("vec%0d_flag", i), tv[i].eflag);
            exp_none($sformatf("vec%0d", i));
        end

        // Distance 1: add r1 = 5 + 3, then sub r2 = r1 - 2
        rf_reinit();
        send(3'd2, 4'd5, 4'd3, 8'h00, 1'b0, 4'd1, 1'b1, st);
        send(3'd3, 4'd1, 4'd0, 8'h02, 1'b1, 4'd2, 1'b1, st);
        chk("d1_stall_cycles", st, EXP_STALL_D1);
        chk("d1_alu_A", alu_A, 16'h0008);
        chk("d1_alu_B", alu_B, 16'h0002);
        drain();
        exp_wb("d1_add", 4'd1, 16'h0008);
        exp_wb("d1_sub", 4'd2, 16'h0006);
        exp_none("d1");

        // Distance 2: add r1, or r3 = r0 | r0, and r4 = r1 & 0x0C
        rf_reinit();
        send(3'd2, 4'd5, 4'd3, 8'h00, 1'b0, 4'd1, 1'b1, st);
        send(3'd1, 4'd0, 4'd0, 8'h00, 1'b0, 4'd3, 1'b1, st);
        chk("d2_or_stall", st, 0);
        send(3'd0, 4'd1, 4'd0, 8'h0C, 1'b1, 4'd4, 1'b1, st);
        chk("d2_and_stall", st, EXP_STALL_D2);
        chk("d2_alu_A", alu_A, 16'h0008);
        drain();
        exp_wb("d2_add", 4'd1, 16'h0008);
        exp_wb("d2_or",  4'd3, 16'h0000);
        exp_wb("d2_and", 4'd4, 16'h0008);
        exp_none("d2");

        // slt r9 = (r2 < r7), then add r10 = r9 + r0 with no forwarding
        rf_reinit();
        send(3'd5, 4'd2, 4'd7, 8'h00, 1'b0, 4'd9, 1'b1, st);
        send(3'd2, 4'd9, 4'd0, 8'h00, 1'b0, 4'd10, 1'b1, st);
        chk("slt_dep_stall", st, 0);
        chk("slt_dep_alu_A", alu_A, 16'h0009);
        drain();
        exp_flag("slt_flag", 1'b1);
        exp_wb("slt_dep_add", 4'd10, 16'h0009);
        exp_none("slt");

        // hold for 3 cycles while a dependent or r12 = r11 | r0 waits
        rf_reinit();
        send(3'd2, 4'd5, 4'd6, 8'h00, 1'b0, 4'd11, 1'b1, st);
        hold = 1'b1;
        set_instr(3'd1, 4'd11, 4'd0, 8'h00, 1'b0, 4'd12, 1'b1);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_in_ready", c), in_ready, 0);
            if (c > 0) chk($sformatf("hold%0d_alu_op", c), alu_op, 7);
            if (c == 1) begin
                chk("hold_wb_valid", wb_valid, 1);
                chk("hold_wb_dst",   wb_dst,   11);
            end
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        @(negedge clk);
        chk("hold_resume_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("hold_resume_op", alu_op, 1);
        chk("hold_resume_A",  alu_A,  16'h000B);
        drain();
        exp_wb("hold_add", 4'd11, 16'h000B);
        exp_wb("hold_or",  4'd12, 16'h000B);
        exp_none("hold");

        // Reset while an add is in writeback and a dependent sub is waiting
        rf_reinit();
        send(3'd2, 4'd5, 4'd3, 8'h00, 1'b0, 4'd1, 1'b1, st);
        set_instr(3'd3, 4'd1, 4'd0, 8'h02, 1'b1, 4'd2, 1'b1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_wb_valid", wb_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_valid",   wb_valid,   0);
        chk("mid_rst_wb_dst",     wb_dst,     0);
        chk("mid_rst_flag_valid", flag_valid, 0);
        chk("mid_rst_in_ready",   in_ready,   0);
        chk("mid_rst_alu_op",     alu_op,     7);
        chk("mid_rst_alu_A",      alu_A,      0);
        chk("mid_rst_alu_B",      alu_B,      0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        exp_none("mid_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand/issue stage directly upstream of the 16-bit ALU (registered ALU, ops 0-5: and, or, add, sub, shift, slt).
- Accepts decoded instructions over a valid/ready handshake and selects B from the register value or a sign-extended immediate.
- Drives the ALU's A/B/op and resolves read-after-write hazards against the two youngest in-flight results.
- Tags the ALU's R/AltB outputs into a writeback bundle for the register file.

Parameters:
- DATA_W, 16: operand/result width; must match the ALU.
- REG_AW, 4: register address width (16 registers).
- IMM_W, 8: immediate width; sign-extended to DATA_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  3  ALU op code.
- in_a  in  DATA_W  register-file value for source A.
- in_b  in  DATA_W  register-file value for source B.
- in_imm  in  IMM_W  immediate.
- in_imm_sel  in  1  1 = B taken from sign-extended in_imm.
- in_src_a  in  REG_AW  source A register address.
- in_src_b  in  REG_AW  source B register address (ignored when in_imm_sel = 1).
- in_dst  in  REG_AW  destination register address.
- in_wr_en  in  1  instruction writes in_dst.
- hold  in  1  downstream freeze; no accept while high.
- alu_A  out  DATA_W  ALU operand A.
- alu_B  out  DATA_W  ALU operand B.
- alu_op  out  3  ALU op.
- alu_R  in  DATA_W  ALU result.
- alu_AltB  in  1  ALU slt flag.
- wb_valid  out  1  register write this cycle.
- wb_dst  out  REG_AW  write address.
- wb_data  out  DATA_W  equals alu_R.
- flag_valid  out  1  AltB updated by a retiring slt.
- flag  out  1  equals alu_AltB.

Behaviour:
- **Reset:**
  - Async assert clears issue register and writeback tag: iss_valid = 0, alu_op = 7 (NOP), alu_A/alu_B operand registers = 0.
  - wb_valid = 0, wb_dst = 0, flag_valid = 0.
  - Reset mid-operation discards all in-flight instructions.
  - in_ready is low while rst_n = 0.
- **Handshake:**
  - in_ready = ~hold & ~hazard_stall (hazard_stall is always 0 when forwarding is compiled in).
  - Accept on in_valid & in_ready at a rising edge; one instruction per cycle max.
- **Issue register:**
  - On accept, latch op, operands, dst, wr_en and iss_valid = 1.
  - With no accept, iss_valid = 0 and alu_op = 7; ALU R and AltB hold.
- **Op legality:**
  - Ops 6/7 are accepted but issue as NOP: no write, no flag.
  - Op 5 (slt) never writes a register (wr_en forced 0); it produces flag_valid instead.
  - Op 4 passes B unchanged; the ALU interprets its sign.
- **Latency:**
  - Instruction accepted at edge k drives the ALU during cycle k..k+1; the ALU samples at k+1.
  - wb_valid/flag_valid assert for the cycle after k+1 (from a tag register loaded at k+1).
  - wb_data = alu_R combinationally in that cycle.
- **Distance-1 hazard (issue-time forwarding):**
  - Condition: new source == issue-register dst, issue wr_en = 1, issue op in 0..4.
  - Set fwd flag at accept; while the flag is set, alu_A/alu_B mux in alu_R instead of the latched operand.
- **Distance-2 hazard (accept-time forwarding):**
  - Condition: new source == writeback tag dst with wb_valid = 1.
  - Latch alu_R instead of in_a/in_b.
  - Distance-1 match takes priority over distance-2 for the same source.
- **Register-address rules:**
  - Immediate B never forwards.
  - A source matching dst of a slt or NOP never forwards.
  - Register 0 is not special.
- **hold:**
  - hold = 1 inserts NOP issues; in-flight instructions still retire normally.
  - Forwarding across bubbles uses the distance-2 path only while the producer is in writeback. Once retired, the register file is assumed current at in_a/in_b.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: forwarding as above; hazard_stall = 0.
- Undefined:
  - No muxes.
  - hazard_stall = 1 while any source matches an issue-register or writeback-tag dst with write enabled; a dependent instruction waits 1-2 cycles.
  - wb_data/timing otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams: OP_AND = 0, OP_OR = 1, OP_ADD = 2, OP_SUB = 3, OP_SHIFT = 4, OP_SLT = 5, OP_NOP = 7.
  - DATA_W, REG_AW defaults.
  - Function writes_reg(op).
- One sub-module, alu_fwd_match: combinational compare of one source address against the issue and writeback tags, returning {sel_alu_issue, sel_alu_wb, stall}. Instantiated twice (A, B).

Test Plan:
- Reset then add r1 = 5 + 3 (in_a = 5, in_b = 3, op = 2): wb_valid two edges after accept, wb_dst = 1, wb_data = 8; outputs 0 during reset.
- Back-to-back add r1 = 5 + 3, then sub r2 = r1 - 2 (in_a = stale 0, imm 2): alu_A = 8 via issue forward; wb r2 = 6; in_ready never drops (FWD_EN).
- Distance-2: add r1 = 8, or r3 = 0|0, and r4 = r1 & 0x000C: r4 = 0x0008 via accept-time forward.
- slt with A = 2, B = 7, then add using src = its dst: flag_valid = 1, flag = 1, wb_valid = 0 for the slt; add uses in_a unforwarded.
- hold = 1 for 3 cycles with in_valid = 1: in_ready = 0, alu_op = 7, wb of prior instruction still occurs; accept resumes on first cycle with hold = 0.
- Without ALU_ISSUE_FWD_EN, dependent sub after add: in_ready low 2 cycles; in_a then = 8 from testbench regfile; result 6; rst_n pulse mid-stall clears wb_valid immediately.
